weight_pingpong_buf: RTL and testbench

WEIGHT_PINGPONG_BUF -- requirements
Module: weight_pingpong_buf

---
 rtl/weight_pingpong_buf_pkg.sv | 19 +
 rtl/weight_pingpong_buf_if.sv | 32 +++
 rtl/wpp_bank_ram.sv | 31 +++
 rtl/weight_pingpong_buf.sv | 148 ++++++++++++++
 tb/tb_weight_pingpong_buf.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_pingpong_buf_pkg.sv
// Shared definitions for the weight ping-pong buffer.
//   CALC_CH_W           : channels per tap in one weight entry
//   WEIGHT_SRAM_ADDRESS : entry address width of one bank
//   DOUT_WIDTH          : entry width in bits (9 taps x CALC_CH_W ch x 8 b)
//   rd_state_e          : read-side FSM encoding
package weight_pingpong_buf_pkg;

  localparam int CALC_CH_W           = 16;
  localparam int WEIGHT_SRAM_ADDRESS = 5;
  localparam int DOUT_WIDTH          = 9 * CALC_CH_W * 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BANK,
    READ,
    DONE
  } rd_state_e;

endpackage

// File: rtl/weight_pingpong_buf_if.sv
// Loader / consumer bus of the weight ping-pong buffer.
//   loader side  : w_en, w_addr, w_data, load_done -> ; <- load_ready, ovf_err
//   consumer side: rd_start, rd_ready -> ; <- rd_vld, rd_data, rd_done
// master = loader + PE array, slave = the buffer.
interface weight_pingpong_buf_if #(
  parameter int WEIGHT_SRAM_ADDRESS = weight_pingpong_buf_pkg::WEIGHT_SRAM_ADDRESS,
  parameter int DOUT_WIDTH          = weight_pingpong_buf_pkg::DOUT_WIDTH
);

  logic                           w_en;
  logic [WEIGHT_SRAM_ADDRESS-1:0] w_addr;
  logic [DOUT_WIDTH-1:0]          w_data;
  logic                           load_done;
  logic                           load_ready;
  logic                           rd_start;
  logic                           rd_ready;
  logic                           rd_vld;
  logic [DOUT_WIDTH-1:0]          rd_data;
  logic                           rd_done;
  logic                           ovf_err;

  modport master (
    output w_en, w_addr, w_data, load_done, rd_start, rd_ready,
    input  load_ready, rd_vld, rd_data, rd_done, ovf_err
  );

  modport slave (
    input  w_en, w_addr, w_data, load_done, rd_start, rd_ready,
    output load_ready, rd_vld, rd_data, rd_done, ovf_err
  );

endinterface

// File: rtl/wpp_bank_ram.sv
// One weight bank: 1R1W synchronous RAM, 2^AW x DW, registered read data.
//   clk, rstn    : clock, async active-low reset (output register only)
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re, held otherwise
module wpp_bank_ram #(
  parameter int AW = 5,
  parameter int DW = 1152
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only loads on re, so it holds the beat through stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_pingpong_buf.sv
// Double-buffered weight store between the weight loader and the PE array.
// The loader fills one bank and closes it with load_done; the consumer asks
// for the next full bank with rd_start and receives it as a valid/ready
// stream, followed by a one-cycle rd_done that releases the bank.
//   clk, rstn : clock, async active-low reset
//   bus       : weight_pingpong_buf_if.slave (loader + consumer signals)
module weight_pingpong_buf #(
  parameter int WEIGHT_SRAM_ADDRESS = weight_pingpong_buf_pkg::WEIGHT_SRAM_ADDRESS,
  parameter int DOUT_WIDTH          = weight_pingpong_buf_pkg::DOUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  weight_pingpong_buf_if.slave  bus
);

  import weight_pingpong_buf_pkg::*;

  localparam int AW = WEIGHT_SRAM_ADDRESS;
  localparam int DW = DOUT_WIDTH;

  typedef logic [AW:0] cnt_t;

  rd_state_e     state, state_d;
  logic [1:0]    full;
  cnt_t          count [2];
  logic          wr_sel, rd_sel;
  logic          ovf_q;
  cnt_t          iss_cnt, iss_cnt_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_issue;
  logic          load_ready, wr_ok, ld_ok, release_bank;
  cnt_t          waddr_p1, rd_cnt;
  logic [DW-1:0] rdata0, rdata1;

  assign load_ready   = ~full[wr_sel];
  assign wr_ok        = bus.w_en & load_ready;
  assign ld_ok        = bus.load_done & load_ready;
  assign waddr_p1     = {1'b0, bus.w_addr} + cnt_t'(1);
  assign rd_cnt       = count[rd_sel];
  assign release_bank = (state == DONE);

  // Bank bookkeeping. Writes and load_done only touch the non-full write
  // bank, the release only the full read bank, so the three updates never
  // collide on one bank. A released bank's count is cleared at release,
  // which keeps the max() update correct when the bank is refilled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full     <= '0;
      count[0] <= '0;
      count[1] <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok && (waddr_p1 > count[wr_sel])) count[wr_sel] <= waddr_p1;
      if (ld_ok) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
        if (!full[~wr_sel]) count[~wr_sel] <= '0;
      end
      if (release_bank) begin
        full[rd_sel]  <= 1'b0;
        count[rd_sel] <= '0;
        rd_sel        <= ~rd_sel;
      end
      if ((bus.w_en | bus.load_done) & ~load_ready) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      iss_cnt  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state    <= state_d;
      iss_cnt  <= iss_cnt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Issue whenever the output register is empty or being drained this
  // cycle; once everything is issued, the same condition means the last
  // beat has been accepted (or there was none), so the bank is finished.
  always_comb begin
    state_d   = state;
    iss_cnt_d = iss_cnt;
    rd_issue  = 1'b0;
    rd_vld_d  = rd_vld_q & ~bus.rd_ready;
    case (state)
      IDLE: begin
        if (bus.rd_start) state_d = WAIT_BANK;
      end
      WAIT_BANK: begin
        if (full[rd_sel]) begin
          state_d   = READ;
          iss_cnt_d = '0;
        end
      end
      READ: begin
        if (~rd_vld_q | bus.rd_ready) begin
          if (iss_cnt < rd_cnt) begin
            rd_issue  = 1'b1;
            iss_cnt_d = iss_cnt + cnt_t'(1);
            rd_vld_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  wpp_bank_ram #(.AW(AW), .DW(DW)) u_bank0 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok & ~wr_sel),
    .waddr (bus.w_addr),
    .wdata (bus.w_data),
    .re    (rd_issue & ~rd_sel),
    .raddr (iss_cnt[AW-1:0]),
    .rdata (rdata0)
  );

  wpp_bank_ram #(.AW(AW), .DW(DW)) u_bank1 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok & wr_sel),
    .waddr (bus.w_addr),
    .wdata (bus.w_data),
    .re    (rd_issue & rd_sel),
    .raddr (iss_cnt[AW-1:0]),
    .rdata (rdata1)
  );

  assign bus.load_ready = load_ready;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.rd_data    = rd_sel ? rdata1 : rdata0;
  assign bus.rd_done    = release_bank;
  assign bus.ovf_err    = ovf_q;

endmodule

// File: tb/tb_weight_pingpong_buf.sv
module tb_weight_pingpong_buf;
  import weight_pingpong_buf_pkg::*;

  localparam int AW    = WEIGHT_SRAM_ADDRESS;
  localparam int DW    = DOUT_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  weight_pingpong_buf_if #(.WEIGHT_SRAM_ADDRESS(AW), .DOUT_WIDTH(DW)) bus ();

  weight_pingpong_buf #(.WEIGHT_SRAM_ADDRESS(AW), .DOUT_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: banks are whole packets; the stream must replay the
  // committed packets in commit order. nfull==2 means the loader is blocked.
  logic [DW-1:0] exp_q [$];
  int            len_q [$];
  logic [DW-1:0] cur_load [DEPTH];
  int            cur_cnt    = 0;
  int            nfull      = 0;
  bit            m_ovf      = 1'b0;
  int            beats_seen = 0;
  int            done_cnt   = 0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream monitor, sampled mid-cycle.
  logic [DW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      len_q.delete();
      beats_seen = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chki("hold_vld", int'(bus.rd_vld), 1);
        chk("hold_data", bus.rd_data, prev_data);
      end
      if (bus.rd_vld && bus.rd_ready) begin
        chki("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("beat_data", bus.rd_data, exp_q.pop_front());
        beats_seen++;
      end
      if (bus.rd_done) begin
        chki("done_len", beats_seen, (len_q.size() > 0) ? len_q.pop_front() : -1);
        beats_seen = 0;
        done_cnt++;
        nfull--;
      end
      prev_stall = bus.rd_vld && !bus.rd_ready;
      prev_data  = bus.rd_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.rd_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    len_q.delete();
    cur_cnt    = 0;
    nfull      = 0;
    m_ovf      = 1'b0;
    beats_seen = 0;
  endtask

  task automatic reset_dut();
    bus.w_en = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.load_done = 1'b0;
    bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
    rand_ready = 1'b0;
    #2;
    rstn = 1'b0;
    model_clear();
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    bus.w_en = 1'b1; bus.w_addr = AW'(a); bus.w_data = d;
    if (nfull < 2) begin
      cur_load[a] = d;
      if (a + 1 > cur_cnt) cur_cnt = a + 1;
    end else m_ovf = 1'b1;
    tick();
    bus.w_en = 1'b0;
  endtask

  task automatic do_load_done();
    bus.load_done = 1'b1;
    if (nfull < 2) begin
      for (int i = 0; i < cur_cnt; i++) exp_q.push_back(cur_load[i]);
      len_q.push_back(cur_cnt);
      nfull++;
      cur_cnt = 0;
    end else m_ovf = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  // All addresses below n written in random order, plus one overwrite.
  task automatic load_bank(input int n);
    int perm [DEPTH];
    int j, t;
    for (int i = 0; i < n; i++) perm[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < n; i++) do_write(perm[i], rnd_data());
    if (n > 0) do_write(int'($urandom_range(0, n - 1)), rnd_data());
    do_load_done();
  endtask

  task automatic pulse_start();
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin tick(); c++; end
    chki("done_timeout", int'(done_cnt >= target), 1);
  endtask

  task automatic wait_vld(input int budget);
    int c = 0;
    while (!bus.rd_vld && c < budget) begin tick(); c++; end
    chki("vld_timeout", int'(bus.rd_vld), 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chki({tag, "_load_ready"}, int'(bus.load_ready), 1);
    chki({tag, "_rd_vld"}, int'(bus.rd_vld), 0);
    chki({tag, "_rd_done"}, int'(bus.rd_done), 0);
    chki({tag, "_ovf"}, int'(bus.ovf_err), 0);
    chk({tag, "_rd_data"}, bus.rd_data, '0);
  endtask

  int tgt;

  initial begin
    bus.w_en = 1'b0; bus.w_addr = '0; bus.w_data = '0; bus.load_done = 1'b0;
    bus.rd_start = 1'b0; bus.rd_ready = 1'b0;

    // Reset state
    reset_dut();
    chk_idle_outputs("reset");

    // Basic 4-entry load and stream with exact latency
    bus.rd_ready = 1'b1;
    for (int a = 0; a < 4; a++) do_write(a, DW'(a));
    do_load_done();
    tgt = done_cnt + 1;
    pulse_start();
    chki("basic_lat0", int'(bus.rd_vld), 0);
    tick();
    chki("basic_lat1", int'(bus.rd_vld), 0);
    for (int a = 0; a < 4; a++) begin
      tick();
      chki("basic_vld", int'(bus.rd_vld), 1);
      chk("basic_data", bus.rd_data, DW'(a));
    end
    tick();
    chki("basic_done", int'(bus.rd_done), 1);
    chki("basic_vld_off", int'(bus.rd_vld), 0);
    tick();
    chki("basic_done_pulse", int'(bus.rd_done), 0);
    chki("basic_load_ready", int'(bus.load_ready), 1);
    chki("basic_done_cnt", done_cnt, tgt);

    // Both banks full, overflow, then drain in order
    reset_dut();
    load_bank(5);
    load_bank(7);
    chki("full_load_ready", int'(bus.load_ready), 0);
    do_write(0, rnd_data());
    chki("ovf_set", int'(bus.ovf_err), 1);
    do_load_done();
    chki("ovf_model", int'(bus.ovf_err), int'(m_ovf));
    chki("full_load_ready2", int'(bus.load_ready), 0);
    rand_ready = 1'b1;
    tgt = done_cnt;
    pulse_start();
    wait_dones(tgt + 1, 200);
    pulse_start();
    wait_dones(tgt + 2, 200);
    tick();
    chki("drain_load_ready", int'(bus.load_ready), 1);
    chki("ovf_sticky", int'(bus.ovf_err), 1);
    chki("drain_q_empty", exp_q.size(), 0);

    // Consumer stalls 1,0,0,1
    reset_dut();
    load_bank(3);
    tgt = done_cnt + 1;
    pulse_start();
    wait_vld(20);
    bus.rd_ready = 1'b1; tick();
    bus.rd_ready = 1'b0; tick();
    bus.rd_ready = 1'b0; tick();
    bus.rd_ready = 1'b1;
    wait_dones(tgt, 50);
    chki("stall_q_empty", exp_q.size(), 0);

    // rd_start before any bank is loaded
    reset_dut();
    bus.rd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      chki("wait_no_vld", int'(bus.rd_vld), 0);
    end
    do_write(0, rnd_data());
    do_write(1, rnd_data());
    tgt = done_cnt + 1;
    do_load_done();
    chki("wait_lat0", int'(bus.rd_vld), 0);
    tick();
    chki("wait_lat1", int'(bus.rd_vld), 0);
    tick();
    chki("wait_lat2", int'(bus.rd_vld), 1);
    wait_dones(tgt, 50);

    // Empty bank
    reset_dut();
    bus.rd_ready = 1'b1;
    do_load_done();
    tgt = done_cnt + 1;
    pulse_start();
    wait_dones(tgt, 20);
    tick();
    chki("empty_load_ready", int'(bus.load_ready), 1);
    load_bank(2);
    pulse_start();
    wait_dones(tgt + 1, 50);
    chki("empty_q_empty", exp_q.size(), 0);

    // Reset mid-read
    reset_dut();
    bus.rd_ready = 1'b1;
    for (int a = 0; a < 8; a++) do_write(a, DW'(a + 100));
    do_load_done();
    pulse_start();
    wait_vld(20);
    tick();
    tick();
    tgt = done_cnt;
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    chk_idle_outputs("midrst");
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chki("midrst_no_vld", int'(bus.rd_vld), 0);
    end
    chki("midrst_no_done", done_cnt, tgt);
    chki("midrst_load_ready", int'(bus.load_ready), 1);

    // Randomized: load one bank, start reading it while filling the other
    reset_dut();
    rand_ready = 1'b1;
    for (int it = 0; it < 12; it++) begin
      load_bank(int'($urandom_range(0, DEPTH)));
      tgt = done_cnt + 1;
      pulse_start();
      load_bank(int'($urandom_range(0, DEPTH)));
      wait_dones(tgt, 300);
      pulse_start();
      wait_dones(tgt + 1, 300);
    end
    tick();
    chki("rand_q_empty", exp_q.size(), 0);
    chki("rand_load_ready", int'(bus.load_ready), 1);
    chki("rand_ovf", int'(bus.ovf_err), int'(m_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
